// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage between EX/MEM and MEM/WB.
// Non-memory ops pass straight through. Loads and stores run one req/ack
// transaction on a big-endian data bus and hold the pipeline via stallreq.
// Optional build macro MEMBUS_TIMEOUT_EN adds a bus-ack timeout (bus_err).
module mem_access #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_wreg,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic        wb_wreg,
    output logic        stallreq,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        misalign,
    output logic        bus_err
);

    localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
    localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
    localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
    localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
    localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
    localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
    localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
    localparam logic [7:0] EXE_SW_OP  = 8'b11101011;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q;
    logic        bus_req_q, bus_we_q, bus_err_q;
    logic [31:0] bus_addr_q, bus_wdata_q, rdata_q;
    logic [3:0]  bus_sel_q;

    // Decoded view of the presented instruction
    logic        is_load, is_store, is_byte, is_half, is_word, sext;
    logic        misal_c;
    logic [3:0]  sel_c;
    logic [31:0] wdata_c, load_c;
    logic [1:0]  ofs;

    assign ofs = mem_mem_addr[1:0];

    // Op decode, byte enables, store replication and misalignment
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_byte  = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        sext     = 1'b0;
        case (mem_aluop)
            EXE_LB_OP:  begin is_load  = 1'b1; is_byte = 1'b1; sext = 1'b1; end
            EXE_LBU_OP: begin is_load  = 1'b1; is_byte = 1'b1; end
            EXE_LH_OP:  begin is_load  = 1'b1; is_half = 1'b1; sext = 1'b1; end
            EXE_LHU_OP: begin is_load  = 1'b1; is_half = 1'b1; end
            EXE_LW_OP:  begin is_load  = 1'b1; is_word = 1'b1; end
            EXE_SB_OP:  begin is_store = 1'b1; is_byte = 1'b1; end
            EXE_SH_OP:  begin is_store = 1'b1; is_half = 1'b1; end
            EXE_SW_OP:  begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase

        misal_c = (is_half && ofs[0]) || (is_word && (ofs != 2'b00));

        sel_c = 4'b0000;
        if (is_byte) begin
            case (ofs)
                2'b00:   sel_c = 4'b1000;
                2'b01:   sel_c = 4'b0100;
                2'b10:   sel_c = 4'b0010;
                default: sel_c = 4'b0001;
            endcase
        end else if (is_half) begin
            sel_c = ofs[1] ? 4'b0011 : 4'b1100;
        end else if (is_word) begin
            sel_c = 4'b1111;
        end

        wdata_c = 32'h0;
        if (is_store) begin
            if (is_byte)      wdata_c = {4{mem_reg2[7:0]}};
            else if (is_half) wdata_c = {2{mem_reg2[15:0]}};
            else              wdata_c = mem_reg2;
        end
    end

    // Big-endian lane extraction of the returned word, with sign/zero extension
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        case (ofs)
            2'b00:   b = bus_rdata[31:24];
            2'b01:   b = bus_rdata[23:16];
            2'b10:   b = bus_rdata[15:8];
            default: b = bus_rdata[7:0];
        endcase
        h = ofs[1] ? bus_rdata[15:0] : bus_rdata[31:16];
        if (is_byte)      load_c = {{24{sext & b[7]}}, b};
        else if (is_half) load_c = {{16{sext & h[15]}}, h};
        else              load_c = bus_rdata;
    end

`ifdef MEMBUS_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    // Transaction FSM; all bus outputs are registered here
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_sel_q   <= 4'h0;
            bus_wdata_q <= 32'h0;
            rdata_q     <= 32'h0;
            bus_err_q   <= 1'b0;
`ifdef MEMBUS_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    bus_err_q <= 1'b0;
                    if ((is_load || is_store) && !misal_c) begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= is_store;
                        bus_addr_q  <= {mem_mem_addr[31:2], 2'b00};
                        bus_sel_q   <= sel_c;
                        bus_wdata_q <= wdata_c;
                        state_q     <= ACCESS;
`ifdef MEMBUS_TIMEOUT_EN
                        cnt_q       <= '0;
`endif
                    end
                end
                ACCESS: begin
                    if (bus_ack) begin
                        bus_req_q <= 1'b0;
                        rdata_q   <= load_c;
                        state_q   <= DONE;
                    end
`ifdef MEMBUS_TIMEOUT_EN
                    // Ack on the limit cycle takes the branch above instead
                    else if (cnt_q == LIMIT) begin
                        bus_req_q <= 1'b0;
                        bus_err_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    // The finished instruction is still presented; never relaunch
                    bus_err_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write-back steering and pipeline hold
    always_comb begin
        wb_waddr = mem_waddr;
        wb_wdata = mem_wdata;
        wb_wreg  = mem_wreg;
        stallreq = 1'b0;
        misalign = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_load || is_store) begin
                    wb_wreg = 1'b0;
                    if (misal_c) misalign = 1'b1;
                    else         stallreq = 1'b1;
                end
            end
            ACCESS: begin
                wb_wreg  = 1'b0;
                stallreq = 1'b1;
            end
            DONE: begin
                if (is_load)   wb_wdata = rdata_q;
                if (bus_err_q) wb_wreg  = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_sel   = bus_sel_q;
    assign bus_wdata = bus_wdata_q;
`ifdef MEMBUS_TIMEOUT_EN
    assign bus_err   = bus_err_q;
`else
    assign bus_err   = 1'b0;
`endif

endmodule
